dmem_stride_responder: RTL
==========================

# dmem_stride_responder

- Memory-side responder for the strided data-memory request interface.
- Accepts one load and one store request descriptor (req/len/stride/base) from a scalar unit or vector lane initiator and grants one of them.
- For the granted request it generates the strided address sequence, drives a single-port synchronous data memory, and returns load data or absorbs store data element by element.
- Signals completion to the initiator with a one-cycle done pulse.

## Interface
Parameters:
- WIDTH_DATA, 32, data word width
- SIZE_DATA_MEM, 1024, memory depth in words
- WIDTH_SIZE_DMEM, $clog2(SIZE_DATA_MEM) = 10, address/len/stride width

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- I_Ld_Req  in  1  load request; held high until granted
- I_Ld_Len / I_Ld_Stride / I_Ld_Base  in  WIDTH_SIZE_DMEM each  load element count, stride, base address
- I_St_Req  in  1  store request; held high until granted
- I_St_Len / I_St_Stride / I_St_Base  in  WIDTH_SIZE_DMEM each  store descriptor
- O_Ld_Grant / O_St_Grant  out  1  one-cycle grant pulse
- O_Ld_Valid  out  1  load data element valid
- O_Ld_Data  out  WIDTH_DATA  load data element
- O_Ld_Done  out  1  pulse with final load element (or alone for len=0)
- I_St_Valid  in  1  store data element valid
- I_St_Data  in  WIDTH_DATA  store data element
- O_St_Ready  out  1  store data accepted when I_St_Valid && O_St_Ready
- O_St_Done  out  1  one-cycle store completion pulse
- O_Mem_Req / O_Mem_We  out  1  memory access enable / write enable
- O_Mem_Addr  out  WIDTH_SIZE_DMEM  memory address
- O_Mem_WData  out  WIDTH_DATA  write data
- I_Mem_RData  in  WIDTH_DATA  read data, valid one cycle after a read request
- O_Busy  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE: waiting for a request
  - LD_RUN: issuing load reads
  - ST_RUN: accepting store writes
- Descriptor latch:
  - In IDLE, the request is sampled; len, stride and base are latched on grant.
  - The element counter cnt is cleared and the current address cur is set to base.
- Arbitration in IDLE: load has fixed priority.
  - A store request that arrives together with a load request stays pending.
  - It is granted in the first IDLE cycle after the load completes, provided it is still held.
- Requests asserted while busy are not sampled until the FSM returns to IDLE.
- Address rule: cur_next = (cur + stride) mod SIZE_DATA_MEM. Wrap-around is silent. Stride 0 repeats base.
- LD_RUN:
  - Drives O_Mem_Req=1, O_Mem_We=0, O_Mem_Addr=cur every cycle, then advances cur and cnt.
  - Leaves to IDLE after the read with cnt = len-1.
- ST_RUN:
  - O_St_Ready=1.
  - On each cycle with I_St_Valid=1, drives O_Mem_Req=1, O_Mem_We=1, O_Mem_Addr=cur and O_Mem_WData=I_St_Data combinationally, then advances cur and cnt.
  - Cycles with I_St_Valid=0 do not advance.
  - Leaves to IDLE after the len-th accepted write.
- len=0: the request is granted but no memory access occurs and the FSM stays in IDLE.
  - The grant and done pulses are asserted in the same cycle.
- O_Mem_Req=0, O_St_Ready=0 in IDLE and LD_RUN (except as stated above).
- Reset mid-operation clears the FSM to IDLE, aborts the transfer and drops pending valid/done. No completion is signalled.
- Reset values: all outputs 0, state IDLE, cnt=0, cur=0.

## Timing
- Grant: request sampled in IDLE cycle T. The grant pulse appears at T+1 (registered), the first cycle of RUN.
- Load latency:
  - Reads are issued at T+1 .. T+len.
  - O_Ld_Valid is the read request delayed one cycle, and O_Ld_Data = I_Mem_RData.
  - Elements are therefore valid at T+2 .. T+len+1.
  - O_Ld_Done is asserted at T+len+1, together with the last O_Ld_Valid.
- Load has no backpressure: one element per cycle, throughput 1.
- FSM is in IDLE at T+len+1. A new request sampled there is granted at T+len+2.
- Store: the write of accepted element k occurs in the cycle it is accepted. O_St_Done is registered, one cycle after the last write.
- len=0: O_Ld_Grant/O_Ld_Done (or O_St_Grant/O_St_Done) pulse together at T+1.

## Test plan
- Load base=10, stride=3, len=4 with memory preloaded mem[a]=a+100.
  - Grant at T+1; reads at addresses 10,13,16,19.
  - O_Ld_Data 110,113,116,119 at T+2..T+5; O_Ld_Done at T+5.
- Store base=1020, stride=2, len=3, data 0xA,0xB,0xC with an I_St_Valid bubble after the first element.
  - Writes to 1020, 1022, 0 (wrap).
  - No write during the bubble; O_St_Done one cycle after the third write.
- Simultaneous load (len=2) and store (len=2) requests, both held.
  - Load granted first.
  - Store granted in the cycle after the load's done cycle (T+4).
  - No memory cycle overlap.
- len=0 load.
  - O_Ld_Grant and O_Ld_Done in the same cycle; O_Mem_Req never asserted; O_Busy stays 0.
- Stride=0, len=3, base=7.
  - Three reads from address 7; cnt and done timing unchanged.
- Assert reset in the middle of a len=8 load after 3 reads.
  - All outputs 0 immediately; no O_Ld_Done.
  - After release with the request still held, the load is re-granted from base.

Source files
------------

// File: rtl/dmem_stride_responder.sv
// dmem_stride_responder: grants one strided load/store descriptor and walks its addresses on a single-port data memory
module dmem_stride_responder #(
  parameter int WIDTH_DATA      = 32,
  parameter int SIZE_DATA_MEM   = 1024,
  parameter int WIDTH_SIZE_DMEM = $clog2(SIZE_DATA_MEM)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_Ld_Req,
  input  logic [WIDTH_SIZE_DMEM-1:0] I_Ld_Len,
  input  logic [WIDTH_SIZE_DMEM-1:0] I_Ld_Stride,
  input  logic [WIDTH_SIZE_DMEM-1:0] I_Ld_Base,
  input  logic                       I_St_Req,
  input  logic [WIDTH_SIZE_DMEM-1:0] I_St_Len,
  input  logic [WIDTH_SIZE_DMEM-1:0] I_St_Stride,
  input  logic [WIDTH_SIZE_DMEM-1:0] I_St_Base,
  output logic                       O_Ld_Grant,
  output logic                       O_St_Grant,
  output logic                       O_Ld_Valid,
  output logic [WIDTH_DATA-1:0]      O_Ld_Data,
  output logic                       O_Ld_Done,
  input  logic                       I_St_Valid,
  input  logic [WIDTH_DATA-1:0]      I_St_Data,
  output logic                       O_St_Ready,
  output logic                       O_St_Done,
  output logic                       O_Mem_Req,
  output logic                       O_Mem_We,
  output logic [WIDTH_SIZE_DMEM-1:0] O_Mem_Addr,
  output logic [WIDTH_DATA-1:0]      O_Mem_WData,
  input  logic [WIDTH_DATA-1:0]      I_Mem_RData,
  output logic                       O_Busy
);
  localparam logic [WIDTH_SIZE_DMEM:0] mem_sz = (WIDTH_SIZE_DMEM+1)'(SIZE_DATA_MEM);
  typedef enum logic [1:0] {IDLE, LD_RUN, ST_RUN} state_t;
  state_t state;
  logic [WIDTH_SIZE_DMEM-1:0] len, stride, cur, cnt, cur_next;
  logic [WIDTH_SIZE_DMEM-1:0] sel_len, sel_stride, sel_base;
  logic [WIDTH_SIZE_DMEM:0] sum;
  logic last, st_fire, take;
  assign sum        = {1'b0, cur} + {1'b0, stride};
  assign cur_next   = WIDTH_SIZE_DMEM'(sum % mem_sz);
  assign last       = cnt == len - 1'b1;
  assign st_fire    = state == ST_RUN && I_St_Valid;
  // a grant visible this cycle means its request is still high; don't grant it twice
  assign take       = !O_Ld_Grant && !O_St_Grant && (I_Ld_Req || I_St_Req);
  assign sel_len    = I_Ld_Req ? I_Ld_Len : I_St_Len;
  assign sel_stride = I_Ld_Req ? I_Ld_Stride : I_St_Stride;
  assign sel_base   = I_Ld_Req ? I_Ld_Base : I_St_Base;
  assign O_Busy      = state != IDLE;
  assign O_St_Ready  = state == ST_RUN;
  assign O_Mem_Req   = state == LD_RUN || st_fire;
  assign O_Mem_We    = st_fire;
  assign O_Mem_Addr  = O_Mem_Req ? cur : '0;
  assign O_Mem_WData = st_fire ? I_St_Data : '0;
  assign O_Ld_Data   = O_Ld_Valid ? I_Mem_RData : '0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      len        <= '0;
      stride     <= '0;
      cur        <= '0;
      cnt        <= '0;
      O_Ld_Grant <= 1'b0;
      O_St_Grant <= 1'b0;
      O_Ld_Valid <= 1'b0;
      O_Ld_Done  <= 1'b0;
      O_St_Done  <= 1'b0;
    end else begin
      O_Ld_Grant <= 1'b0;
      O_St_Grant <= 1'b0;
      O_Ld_Done  <= 1'b0;
      O_St_Done  <= 1'b0;
      O_Ld_Valid <= state == LD_RUN;
      case (state)
        IDLE: if (take) begin
          len        <= sel_len;
          stride     <= sel_stride;
          cur        <= sel_base;
          cnt        <= '0;
          O_Ld_Grant <= I_Ld_Req;
          O_St_Grant <= !I_Ld_Req;
          if (sel_len == '0) begin
            O_Ld_Done <= I_Ld_Req;
            O_St_Done <= !I_Ld_Req;
          end else state <= I_Ld_Req ? LD_RUN : ST_RUN;
        end
        LD_RUN: begin
          cur <= cur_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            state     <= IDLE;
            O_Ld_Done <= 1'b1;
          end
        end
        ST_RUN: if (I_St_Valid) begin
          cur <= cur_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            state     <= IDLE;
            O_St_Done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
